// File: rtl/fifo_syn_prog_pkg.sv
// fifo_syn_prog_pkg: shared default sizing for the single-clock FIFO family.
// No ports; imported by fifo_syn_prog and fifo_syn_mem for parameter defaults.
package fifo_syn_prog_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
endpackage

// File: rtl/fifo_syn_mem.sv
// fifo_syn_mem: DEPTH x DATA_WIDTH register array, gated write port, combinational read.
// Ports: clk; we/wr_addr/wr_data write port; rd_addr -> rd_data asynchronous read.
// The array has no reset: contents survive a FIFO reset and are simply overwritten.
module fifo_syn_mem
    import fifo_syn_prog_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/fifo_syn_prog.sv
// fifo_syn_prog: single-clock FIFO with programmable almost-full/almost-empty,
// occupancy count and sticky overflow/underflow flags.
// Ports: clk, rst (async, active-high); wr_en/wr_data write side; rd_en pop,
// rd_data/rd_valid read side; wr_full, rd_empty, fill_count status;
// af_thresh/ae_thresh -> almost_full/almost_empty; clr_err clears overflow/underflow.
// Macro FIFO_SYN_FWFT_EN selects first-word-fall-through (zero read latency);
// undefined gives a registered read with one cycle of latency.
module fifo_syn_prog
    import fifo_syn_prog_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  wr_full,
    output logic                  rd_empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_d;
    logic overflow_q, overflow_d, underflow_q, underflow_d;
    logic almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
    logic rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] mem_rd;

    // Extra pointer MSB tells a full buffer from an empty one.
    assign fill_count = wr_ptr_q - rd_ptr_q;
    assign rd_empty   = wr_ptr_q == rd_ptr_q;
    assign wr_full    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_WIDTH{1'b0}}};

    always_comb begin
        rd_acc         = rd_en & ~rd_empty;
        // A read in the same cycle frees the slot a write into a full FIFO needs.
        wr_acc         = wr_en & (~wr_full | rd_acc);
        wr_ptr_d       = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d       = rd_ptr_q + PW'(rd_acc);
        cnt_d          = wr_ptr_d - rd_ptr_d;
        // Flags are registered against the post-edge count so a threshold
        // change shows up one edge later.
        almost_full_d  = cnt_d >= af_thresh;
        almost_empty_d = cnt_d <= ae_thresh;
        overflow_d     = (wr_en & ~wr_acc) | (overflow_q & ~clr_err);
        underflow_d    = (rd_en & ~rd_acc) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;

    fifo_syn_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .we     (wr_acc),
        .wr_addr(wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data(wr_data),
        .rd_addr(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data(mem_rd)
    );

`ifdef FIFO_SYN_FWFT_EN
    assign rd_data  = mem_rd;
    assign rd_valid = ~rd_empty;
`else
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_acc ? mem_rd : rd_data_q;
        rd_valid_d = rd_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_fifo_syn_prog.sv
// tb_fifo_syn_prog: queue-model scoreboard bench for fifo_syn_prog.
module tb_fifo_syn_prog;
    localparam int DEPTH = 16;
`ifdef FIFO_SYN_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, wr_full, rd_empty, almost_full, almost_empty;
    logic [4:0] af_thresh = 5'd12;
    logic [4:0] ae_thresh = 5'd3;
    logic [4:0] fill_count;
    logic       clr_err = 1'b0;
    logic       overflow, underflow;

    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    bit m_ovf = 0, m_unf = 0, m_af = 0, m_ae = 1;

    fifo_syn_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_full(wr_full), .rd_empty(rd_empty),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(almost_full),
        .almost_empty(almost_empty), .fill_count(fill_count), .clr_err(clr_err),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf = 0; m_unf = 0; m_af = 0; m_ae = 1;
    endtask

    // FIFO behaviour from the accept rules, with a queue as the storage.
    task automatic model_step();
        bit ra, wa;
        logic [7:0] w;
        ra = rd_en && mq.size() > 0;
        wa = wr_en && (mq.size() < DEPTH || ra);
        if (ra) begin
            w = mq.pop_front();
            if (!FWFT) exp_q.push_back(w);
        end
        if (wa) mq.push_back(wr_data);
        m_ovf = (wr_en && !wa) || (m_ovf && !clr_err);
        m_unf = (rd_en && !ra) || (m_unf && !clr_err);
        m_af  = mq.size() >= int'(af_thresh);
        m_ae  = mq.size() <= int'(ae_thresh);
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        @(posedge clk);
        model_step();
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    // Monitor: compares every status output and pops the scoreboard on rd_valid.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("fill_count", 32'(fill_count), 32'(mq.size()));
            chk("wr_full", 32'(wr_full), 32'(mq.size() == DEPTH));
            chk("rd_empty", 32'(rd_empty), 32'(mq.size() == 0));
            chk("almost_full", 32'(almost_full), 32'(m_af));
            chk("almost_empty", 32'(almost_empty), 32'(m_ae));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_SYN_FWFT_EN
            chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
`else
            chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
`endif
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst fill_count", 32'(fill_count), 0);
        chk("rst rd_empty", 32'(rd_empty), 1);
        chk("rst wr_full", 32'(wr_full), 0);
        chk("rst rd_valid", 32'(rd_valid), 0);
        chk("rst almost_empty", 32'(almost_empty), 1);
        chk("rst almost_full", 32'(almost_full), 0);
        chk("rst overflow", 32'(overflow), 0);
        chk("rst underflow", 32'(underflow), 0);
        if (!FWFT) chk("rst rd_data", 32'(rd_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("full after 16", 32'(wr_full), 1);
        chk("count after 16", 32'(fill_count), 16);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("overflow on 17th", 32'(overflow), 1);
        chk("count after 17th", 32'(fill_count), 16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("overflow cleared", 32'(overflow), 0);

        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("empty after drain", 32'(rd_empty), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("underflow on empty read", 32'(underflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        chk("full rw count", 32'(fill_count), 16);
        chk("full rw no overflow", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("empty rw count", 32'(fill_count), 1);
        chk("empty rw underflow", 32'(underflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("underflow cleared", 32'(underflow), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) af_thresh = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 31) == 0) ae_thresh = 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 7) == 0));
        end

        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        for (int i = 0; i < 18; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst fill_count", 32'(fill_count), 0);
        chk("midrst rd_empty", 32'(rd_empty), 1);
        chk("midrst wr_full", 32'(wr_full), 0);
        chk("midrst rd_valid", 32'(rd_valid), 0);
        chk("midrst overflow", 32'(overflow), 0);
        chk("midrst underflow", 32'(underflow), 0);
        chk("midrst almost_empty", 32'(almost_empty), 1);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        if (FWFT) chk("post-rst fwft word", 32'(rd_data), 32'h A5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        if (!FWFT) chk("post-rst word", 32'(rd_data), 32'h A5);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
